lcd_pixel_arbiter: RTL and testbench

LCD_PIXEL_ARBITER -- requirements
Module: lcd_pixel_arbiter

---
 rtl/lcd_scope_pkg.sv | 17 +
 rtl/lcd_pixel_arbiter.sv | 131 +++++++++++++
 tb/tb_lcd_pixel_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_scope_pkg.sv
// Shared display-scope constants and the pixel arbiter state encoding.
// The top-level display wrapper imports the same constants.
package lcd_scope_pkg;

  localparam int LCD_W   = 240;
  localparam int LCD_H   = 320;
  localparam int X_W     = 8;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/lcd_pixel_arbiter.sv
// Two-requester round-robin pixel arbiter in front of the LCD write port;
// bursts are capped at MAX_BURST beats while the other side waits, and off-screen pixels are clipped.
module lcd_pixel_arbiter #(
  parameter int LCD_W     = lcd_scope_pkg::LCD_W,
  parameter int LCD_H     = lcd_scope_pkg::LCD_H,
  parameter int MAX_BURST = 16
) (
  input  logic        clock,
  input  logic        rstApp,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  x0,
  input  logic [7:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  input  logic        pixelReady,
  output logic [1:0]  grant,
  output logic        busy
);

  import lcd_scope_pkg::*;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_t           state, state_nxt, other_state;
  logic                 rr, rr_nxt;
  logic [7:0]           bcnt, bcnt_nxt;
  logic                 cur_idx;
  logic                 sel_req, other_req;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [COLOR_W-1:0]   sel_data;
  logic                 inrange, beat_done;

  assign cur_idx     = (state == GNT1);
  assign other_state = (state == GNT0) ? GNT1 : GNT0;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel_req   = 1'b0;
    other_req = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_data  = '0;
    unique case (state)
      GNT0: begin
        sel_req   = req0;
        other_req = req1;
        sel_x     = x0;
        sel_y     = y0;
        sel_data  = data0;
      end
      GNT1: begin
        sel_req   = req1;
        other_req = req0;
        sel_x     = x1;
        sel_y     = y1;
        sel_data  = data1;
      end
      default: ;
    endcase
  end

  // Off-screen beats complete without touching the display, so they never wait on pixelReady.
  assign inrange    = (int'(sel_x) < LCD_W) && (int'(sel_y) < LCD_H);
  assign pixelWrite = sel_req && inrange;
  assign beat_done  = sel_req && (!inrange || pixelReady);

  assign ack0      = beat_done && (state == GNT0);
  assign ack1      = beat_done && (state == GNT1);
  assign xAddr     = sel_x;
  assign yAddr     = sel_y;
  assign pixelData = sel_data;
  assign grant     = {state == GNT1, state == GNT0};
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    bcnt_nxt  = bcnt;
    unique case (state)
      IDLE: begin
        bcnt_nxt = '0;
        if (req0 && req1) state_nxt = rr ? GNT1 : GNT0;
        else if (req0)    state_nxt = GNT0;
        else if (req1)    state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (!sel_req) begin
          rr_nxt    = ~cur_idx;
          bcnt_nxt  = '0;
          state_nxt = other_req ? other_state : IDLE;
        end else if (beat_done) begin
          if (bcnt == BURST_LAST) begin
            // Burst exhausted: hand straight over if the other side waits, else restart the count.
            bcnt_nxt = '0;
            if (other_req) begin
              state_nxt = other_state;
              rr_nxt    = cur_idx;
            end
          end else begin
            bcnt_nxt = bcnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge rstApp) begin
    if (rstApp) begin
      state <= IDLE;
      rr    <= 1'b0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_pixel_arbiter.sv
// Scoreboard bench for lcd_pixel_arbiter: a transaction-level arbitration model predicts
// grants/acks each cycle, and per-requester queues check every consumed pixel exactly once.
module tb_lcd_pixel_arbiter;
  import lcd_scope_pkg::*;

  localparam int MAX_BURST = 4;

  typedef struct {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } pix_t;

  typedef struct {
    logic [1:0]  grant;
    logic        busy;
    logic        a0;
    logic        a1;
    logic        pw;
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } cyc_t;

  logic        clock = 1'b0;
  logic        rstApp = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  x0 = '0, x1 = '0;
  logic [8:0]  y0 = '0, y1 = '0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        pixelReady = 1'b1;
  logic        ack0, ack1, pixelWrite, busy;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic [1:0]  grant;

  lcd_pixel_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .rstApp(rstApp),
    .req0(req0), .req1(req1), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .data0(data0), .data1(data1), .ack0(ack0), .ack1(ack1),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .grant(grant), .busy(busy)
  );

  always #10 clock = ~clock;

  pix_t pend0[$], pend1[$];
  pix_t exp0[$], exp1[$];
  cyc_t cyc_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference arbitration state: who owns the port, beats served in this burst, whose turn on a tie.
  int m_owner = -1;
  int m_beats = 0;
  int m_rr    = 0;

  function automatic bit on_screen(input logic [7:0] x, input logic [8:0] y);
    return (int'(x) < LCD_W) && (int'(y) < LCD_H);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // Model: predict this cycle's outputs, then decide ownership for the next cycle.
  always @(negedge clock) begin
    cyc_t e;
    bit   own_req, oth_req, done;
    e = '{default: '0};
    own_req = 1'b0;
    oth_req = 1'b0;
    done    = 1'b0;
    if (rstApp) begin
      m_owner = -1;
      m_beats = 0;
      m_rr    = 0;
      cyc_q.push_back(e);
    end else begin
      if (m_owner == 0) begin
        own_req = req0; oth_req = req1;
        e.x = x0; e.y = y0; e.d = data0;
        e.pw = req0 && on_screen(x0, y0);
        done = req0 && (!on_screen(x0, y0) || pixelReady);
        e.grant = 2'b01; e.a0 = done;
      end else if (m_owner == 1) begin
        own_req = req1; oth_req = req0;
        e.x = x1; e.y = y1; e.d = data1;
        e.pw = req1 && on_screen(x1, y1);
        done = req1 && (!on_screen(x1, y1) || pixelReady);
        e.grant = 2'b10; e.a1 = done;
      end
      e.busy = (m_owner >= 0);
      cyc_q.push_back(e);

      if (m_owner < 0) begin
        if (req0 && req1) m_owner = m_rr;
        else if (req0)    m_owner = 0;
        else if (req1)    m_owner = 1;
        m_beats = 0;
      end else if (!own_req) begin
        m_rr    = 1 - m_owner;
        m_owner = oth_req ? 1 - m_owner : -1;
        m_beats = 0;
      end else if (done) begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_beats = 0;
          if (oth_req) begin
            m_rr    = m_owner;
            m_owner = 1 - m_owner;
          end
        end
      end
    end
  end

  // Monitor: compare whole-cycle outputs, and each consumed beat against its scoreboard entry.
  always @(negedge clock) begin
    cyc_t e;
    pix_t p;
    #1;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      check("cycle_outputs",
            64'({grant, busy, ack0, ack1, pixelWrite, xAddr, yAddr, pixelData}),
            64'({e.grant, e.busy, e.a0, e.a1, e.pw, e.x, e.y, e.d}));
    end
    if (ack0) begin
      check("ack0_has_pixel", 64'(exp0.size() != 0), 64'(1));
      if (exp0.size() != 0) begin
        p = exp0.pop_front();
        check("beat0", 64'({pixelWrite, xAddr, yAddr, pixelData}),
              64'({on_screen(p.x, p.y), p.x, p.y, p.d}));
      end
    end
    if (ack1) begin
      check("ack1_has_pixel", 64'(exp1.size() != 0), 64'(1));
      if (exp1.size() != 0) begin
        p = exp1.pop_front();
        check("beat1", 64'({pixelWrite, xAddr, yAddr, pixelData}),
              64'({on_screen(p.x, p.y), p.x, p.y, p.d}));
      end
    end
  end

  task automatic apply();
    if (pend0.size() > 0) begin
      req0 = 1'b1; x0 = pend0[0].x; y0 = pend0[0].y; data0 = pend0[0].d;
    end else begin
      req0 = 1'b0;
    end
    if (pend1.size() > 0) begin
      req1 = 1'b1; x1 = pend1[0].x; y1 = pend1[0].y; data1 = pend1[0].d;
    end else begin
      req1 = 1'b0;
    end
  endtask

  task automatic push(input int n, input int x, input int y, input int d);
    pix_t p;
    p.x = 8'(x); p.y = 9'(y); p.d = 16'(d);
    if (n == 0) begin pend0.push_back(p); exp0.push_back(p); end
    else        begin pend1.push_back(p); exp1.push_back(p); end
    apply();
  endtask

  // One clock: observe the handshake, then present the next payload just after the edge.
  task automatic step();
    bit a0, a1;
    @(negedge clock);
    #2;
    a0 = ack0;
    a1 = ack1;
    @(posedge clock);
    #1;
    if (a0 && pend0.size() > 0) void'(pend0.pop_front());
    if (a1 && pend1.size() > 0) void'(pend1.pop_front());
    apply();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_done", 64'(pend0.size() + pend1.size()), 64'(0));
    step();
    step();
  endtask

  initial begin
    repeat (3) step();
    rstApp = 1'b0;
    step();

    // Single on-screen pixel from IDLE.
    pixelReady = 1'b1;
    push(0, 10, 20, 16'hF800);
    drain(20);

    // Both requesters streaming: bursts of MAX_BURST alternate with no idle gap.
    for (int i = 0; i < 12; i++) begin
      push(0, i, i + 1, 16'h1000 + i);
      push(1, 100 + i, 200 + i, 16'h2000 + i);
    end
    drain(100);

    // Display stalls for five cycles while requester 1 owns the port.
    pixelReady = 1'b0;
    push(1, 30, 40, 16'h07E0);
    repeat (6) step();
    pixelReady = 1'b1;
    drain(20);

    // Off-screen pixel is clipped and completes despite a stalled display.
    pixelReady = 1'b0;
    push(0, 240, 5, 16'h001F);
    drain(10);
    push(0, 7, 320, 16'h001E);
    drain(10);
    pixelReady = 1'b1;

    // Reset pulse while requester 1 is stalled abandons the beat.
    pixelReady = 1'b0;
    push(1, 50, 60, 16'hABCD);
    repeat (3) step();
    rstApp = 1'b1;
    repeat (2) step();
    rstApp = 1'b0;
    repeat (2) step();
    pixelReady = 1'b1;
    drain(20);

    // Fresh reset, both pending: requester 0 first, then handover to 1 when 0 drops.
    rstApp = 1'b1;
    step();
    rstApp = 1'b0;
    step();
    push(0, 1, 2, 16'h1111);
    for (int i = 0; i < 3; i++) push(1, 3 + i, 4 + i, 16'h2222 + i);
    drain(20);
    push(0, 9, 9, 16'h3333);
    push(1, 8, 8, 16'h4444);
    drain(20);

    // Random traffic with stalls and some off-screen coordinates.
    for (int c = 0; c < 1500; c++) begin
      pixelReady = ($urandom_range(0, 3) != 0);
      if (pend0.size() < 4 && $urandom_range(0, 2) == 0)
        push(0, $urandom_range(0, 255), $urandom_range(0, 340), $urandom_range(0, 65535));
      if (pend1.size() < 4 && $urandom_range(0, 2) == 0)
        push(1, $urandom_range(0, 255), $urandom_range(0, 340), $urandom_range(0, 65535));
      step();
    end
    pixelReady = 1'b1;
    drain(200);

    check("scoreboard0_empty", 64'(exp0.size()), 64'(0));
    check("scoreboard1_empty", 64'(exp1.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
